// File: rtl/vga_text_pkg.sv
// Shared constants and state type for the register-dump text line writer.
package vga_text_pkg;

  localparam int LINE_CHARS      = 24;
  localparam int PULSES_PER_LINE = 25;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_EQ    = 8'h3D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    FIN  = 2'd3
  } line_state_e;

endpackage

// File: rtl/hex_to_ascii.sv
// Combinational nibble to uppercase ASCII hex digit.
module hex_to_ascii (
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'
  always_comb begin
    if (nibble < 4'd10) ascii = 8'h30 + {4'd0, nibble};
    else                ascii = 8'h37 + {4'd0, nibble};
  end

endmodule

// File: rtl/text_line_writer.sv
// Emits one 25-character text line "Rnn=hhhhhhhh" plus padding, one strobe per character.
module text_line_writer
  import vga_text_pkg::*;
#(
  parameter int HOLD_CYC = 4,
  parameter int GAP_CYC  = 4
) (
  input  logic        iCLK_100,
  input  logic        iCLRN,
  input  logic        start,
  input  logic [4:0]  reg_idx,
  input  logic [31:0] word,
  output logic [7:0]  char_data,
  output logic        ready,
  output logic        en,
  output logic        busy,
  output logic        done
);

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYC - 1);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYC - 1);
  localparam logic [4:0] LAST_K    = 5'(LINE_CHARS);

  line_state_e state;
  logic [7:0]  cnt;
  logic [4:0]  k;
  logic [4:0]  idx_q;
  logic [31:0] word_q;

  logic        accept;
  logic        last_phase;
  logic        advance;
  logic [4:0]  k_nx;
  logic [4:0]  idx_nx;
  logic [31:0] word_nx;
  logic [2:0]  nib_pos;
  logic [3:0]  nibble;
  logic [7:0]  hex_chr;
  logic [1:0]  tens;
  logic [3:0]  ones;
  logic [7:0]  char_nx;

  // The character register is loaded with the value for the character about to
  // start, so the look-up runs on next-cycle k and operands.
  assign accept     = (state == IDLE) && start;
  assign last_phase = (cnt == 8'd0);
  assign advance    = (state == LOW) && last_phase && (k != LAST_K);
  assign k_nx       = accept ? 5'd0 : (advance ? k + 5'd1 : k);
  assign idx_nx     = accept ? reg_idx : idx_q;
  assign word_nx    = accept ? word : word_q;
  assign nib_pos    = 3'(4'd11 - k_nx[3:0]);
  assign nibble     = word_nx[{nib_pos, 2'b00} +: 4];

  hex_to_ascii u_hex (
    .nibble (nibble),
    .ascii  (hex_chr)
  );

  // Decimal split of the register index (0..31)
  always_comb begin
    if (idx_nx >= 5'd30) begin
      tens = 2'd3;
      ones = 4'(idx_nx - 5'd30);
    end else if (idx_nx >= 5'd20) begin
      tens = 2'd2;
      ones = 4'(idx_nx - 5'd20);
    end else if (idx_nx >= 5'd10) begin
      tens = 2'd1;
      ones = 4'(idx_nx - 5'd10);
    end else begin
      tens = 2'd0;
      ones = idx_nx[3:0];
    end
  end

  // Character selected by position within the line
  always_comb begin
    char_nx = ASCII_SPACE;
    if (k_nx == 5'd0)                         char_nx = ASCII_R;
    else if (k_nx == 5'd1)                    char_nx = ASCII_ZERO + {6'd0, tens};
    else if (k_nx == 5'd2)                    char_nx = ASCII_ZERO + {4'd0, ones};
    else if (k_nx == 5'd3)                    char_nx = ASCII_EQ;
    else if (k_nx >= 5'd4 && k_nx <= 5'd11)   char_nx = hex_chr;
  end

  // Line sequencer: one shared down-counter times both strobe phases
  always_ff @(posedge iCLK_100 or negedge iCLRN) begin
    if (!iCLRN) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      k         <= 5'd0;
      idx_q     <= 5'd0;
      word_q    <= 32'd0;
      char_data <= 8'h00;
      ready     <= 1'b0;
      en        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= HIGH;
            cnt       <= HOLD_LOAD;
            k         <= k_nx;
            idx_q     <= reg_idx;
            word_q    <= word;
            char_data <= char_nx;
            ready     <= 1'b1;
            en        <= 1'b1;
            busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (last_phase) begin
            state <= LOW;
            cnt   <= GAP_LOAD;
            ready <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LOW: begin
          if (!last_phase) begin
            cnt <= cnt - 8'd1;
          end else if (advance) begin
            state     <= HIGH;
            cnt       <= HOLD_LOAD;
            k         <= k_nx;
            char_data <= char_nx;
            ready     <= 1'b1;
          end else begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state     <= IDLE;
          char_data <= 8'h00;
          en        <= 1'b0;
          busy      <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_line_writer.sv
// Directed bench for text_line_writer: line content, strobe timing, start handling, reset.
module tb_text_line_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  reg_idx = 5'd0;
  logic [31:0] word = 32'd0;
  logic [7:0]  char_data;
  logic        ready, en, busy, done;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  text_line_writer #(.HOLD_CYC(4), .GAP_CYC(4)) dut (
    .iCLK_100  (clk),
    .iCLRN     (rst_n),
    .start     (start),
    .reg_idx   (reg_idx),
    .word      (word),
    .char_data (char_data),
    .ready     (ready),
    .en        (en),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects strobed characters, phase lengths and done cycles
  logic [7:0] chars[$];
  int         hi_lens[$];
  int         lo_lens[$];
  int         done_cycs[$];
  int         stable_err = 0;
  int         hi_total = 0;
  int         hi_run = 0;
  int         lo_run = 0;
  logic       ready_prev = 1'b0;
  logic [7:0] cur_char = 8'h00;

  always @(negedge clk) begin
    if (ready) begin
      hi_total++;
      if (!ready_prev) begin
        cur_char = char_data;
        hi_run = 0;
        if (lo_run > 0) lo_lens.push_back(lo_run);
        lo_run = 0;
      end else if (char_data !== cur_char) begin
        stable_err++;
      end
      hi_run++;
    end else if (busy && !done) begin
      if (ready_prev) begin
        chars.push_back(cur_char);
        hi_lens.push_back(hi_run);
      end
      if (char_data !== cur_char) stable_err++;
      lo_run++;
    end
    if (done) begin
      done_cycs.push_back(cyc);
      if (lo_run > 0) lo_lens.push_back(lo_run);
      lo_run = 0;
    end
    ready_prev = ready;
  end

  task automatic clear_mon();
    chars.delete();
    hi_lens.delete();
    lo_lens.delete();
    done_cycs.delete();
    stable_err = 0;
    hi_total = 0;
    hi_run = 0;
    lo_run = 0;
    ready_prev = ready;
  endtask

  task automatic start_line(input logic [4:0] idx, input logic [31:0] w, output int acc);
    @(posedge clk); #1;
    reg_idx = idx;
    word = w;
    start = 1'b1;
    acc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (done_cycs.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b want 0", ready); end
    tests++; if (en !== 1'b0) begin fails++; $display("FAIL reset_en got %b want 0", en); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done); end
    tests++; if (char_data !== 8'h00) begin fails++; $display("FAIL reset_char got %h want 00", char_data); end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0 || ready !== 1'b0) begin fails++; $display("FAIL idle_after_reset busy=%b ready=%b want 0 0", busy, ready); end
  endtask

  task automatic test_line_abcd();
    string s;
    int acc;
    bit ok;
    int bad_hi, bad_lo;
    logic [7:0] exp;
    s = "R05=0000ABCD";
    clear_mon();
    start_line(5'd5, 32'h0000ABCD, acc);
    reg_idx = 5'd9;
    word = 32'h12345678;
    wait_done(1, 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL abcd_timeout got no done want done"); end
    tests++; if (chars.size() != 25) begin fails++; $display("FAIL abcd_pulses got %0d want 25", chars.size()); end
    for (int k = 0; k < 25; k++) begin
      exp = (k < 12) ? 8'(s[k]) : 8'h20;
      tests++;
      if (k >= chars.size() || chars[k] !== exp) begin
        fails++;
        $display("FAIL abcd_char%0d got %h want %h", k, (k < chars.size()) ? chars[k] : 8'hxx, exp);
      end
    end
    tests++;
    if (done_cycs.size() < 1 || done_cycs[0] != acc + 201) begin
      fails++;
      $display("FAIL abcd_latency got %0d want %0d", (done_cycs.size() > 0) ? done_cycs[0] - acc : -1, 201);
    end
    bad_hi = 0; bad_lo = 0;
    foreach (hi_lens[i]) if (hi_lens[i] != 4) bad_hi++;
    foreach (lo_lens[i]) if (lo_lens[i] != 4) bad_lo++;
    tests++; if (hi_lens.size() != 25 || bad_hi != 0) begin fails++; $display("FAIL abcd_high_len count=%0d bad=%0d want 25 0", hi_lens.size(), bad_hi); end
    tests++; if (lo_lens.size() != 25 || bad_lo != 0) begin fails++; $display("FAIL abcd_low_len count=%0d bad=%0d want 25 0", lo_lens.size(), bad_lo); end
    tests++; if (stable_err != 0) begin fails++; $display("FAIL abcd_char_stable got %0d changes want 0", stable_err); end
    tests++;
    if (busy !== 1'b0 || en !== 1'b0 || ready !== 1'b0 || char_data !== 8'h00) begin
      fails++;
      $display("FAIL abcd_idle busy=%b en=%b ready=%b char=%h want 0 0 0 00", busy, en, ready, char_data);
    end
  endtask

  task automatic test_max_values();
    int acc;
    bit ok;
    int bad_hex, bad_hi, bad_lo;
    clear_mon();
    start_line(5'd31, 32'hFFFFFFFF, acc);
    wait_done(1, 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL max_timeout got no done want done"); end
    tests++; if (chars.size() != 25) begin fails++; $display("FAIL max_pulses got %0d want 25", chars.size()); end
    tests++; if (chars.size() < 3 || chars[1] !== 8'h33) begin fails++; $display("FAIL max_tens got %h want 33", chars[1]); end
    tests++; if (chars.size() < 3 || chars[2] !== 8'h31) begin fails++; $display("FAIL max_ones got %h want 31", chars[2]); end
    bad_hex = 0;
    for (int k = 4; k < 12; k++) if (k >= chars.size() || chars[k] !== 8'h46) bad_hex++;
    tests++; if (bad_hex != 0) begin fails++; $display("FAIL max_hex_F got %0d wrong want 0", bad_hex); end
    bad_hi = 0; bad_lo = 0;
    foreach (hi_lens[i]) if (hi_lens[i] != 4) bad_hi++;
    foreach (lo_lens[i]) if (lo_lens[i] != 4) bad_lo++;
    tests++; if (hi_lens.size() != 25 || bad_hi != 0) begin fails++; $display("FAIL max_high_len count=%0d bad=%0d want 25 0", hi_lens.size(), bad_hi); end
    tests++; if (lo_lens.size() != 25 || bad_lo != 0) begin fails++; $display("FAIL max_low_len count=%0d bad=%0d want 25 0", lo_lens.size(), bad_lo); end
  endtask

  task automatic test_ignore_start();
    string s;
    int acc;
    bit ok, hit;
    int bad;
    s = "R07=89ABCDEF";
    clear_mon();
    start_line(5'd7, 32'h89ABCDEF, acc);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (chars.size() == 6 && ready) begin hit = 1'b1; break; end
    end
    tests++; if (!hit) begin fails++; $display("FAIL ignore_reach_k6 got no k=6 want k=6"); end
    reg_idx = 5'd2;
    word = 32'h12345678;
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    wait_done(1, 400, ok);
    tests++; if (!ok) begin fails++; $display("FAIL ignore_timeout got no done want done"); end
    bad = 0;
    for (int k = 0; k < 25; k++)
      if (k >= chars.size() || chars[k] !== ((k < 12) ? 8'(s[k]) : 8'h20)) bad++;
    tests++; if (bad != 0) begin fails++; $display("FAIL ignore_line got %0d wrong chars want 0", bad); end
    tests++; if (done_cycs.size() < 1 || done_cycs[0] != acc + 201) begin fails++; $display("FAIL ignore_latency got %0d want 201", (done_cycs.size() > 0) ? done_cycs[0] - acc : -1); end
    repeat (300) @(posedge clk);
    #2;
    tests++; if (chars.size() != 25 || done_cycs.size() != 1) begin fails++; $display("FAIL ignore_no_second pulses=%0d dones=%0d want 25 1", chars.size(), done_cycs.size()); end
  endtask

  task automatic test_reset_mid_line();
    int acc;
    bit hit;
    clear_mon();
    start_line(5'd1, 32'h00000000, acc);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (chars.size() == 7 && ready) begin hit = 1'b1; break; end
    end
    tests++; if (!hit) begin fails++; $display("FAIL rstmid_reach_k7 got no k=7 want k=7"); end
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if (ready !== 1'b0 || en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || char_data !== 8'h00) begin
      fails++;
      $display("FAIL rstmid_outputs ready=%b en=%b busy=%b done=%b char=%h want 0 0 0 0 00", ready, en, busy, done, char_data);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_mon();
    repeat (100) @(posedge clk);
    #2;
    tests++; if (hi_total != 0 || busy !== 1'b0) begin fails++; $display("FAIL rstmid_no_pulses high_cycles=%0d busy=%b want 0 0", hi_total, busy); end
  endtask

  task automatic test_back_to_back();
    int acc;
    bit ok;
    clear_mon();
    @(posedge clk); #1;
    reg_idx = 5'd3;
    word = 32'h0000000A;
    start = 1'b1;
    acc = cyc;
    wait_done(2, 700, ok);
    start = 1'b0;
    tests++; if (!ok) begin fails++; $display("FAIL b2b_timeout got %0d dones want 2", done_cycs.size()); end
    tests++; if (done_cycs.size() < 1 || done_cycs[0] != acc + 201) begin fails++; $display("FAIL b2b_first_latency got %0d want 201", (done_cycs.size() > 0) ? done_cycs[0] - acc : -1); end
    tests++; if (done_cycs.size() < 2 || done_cycs[1] - done_cycs[0] != 202) begin fails++; $display("FAIL b2b_spacing got %0d want 202", (done_cycs.size() > 1) ? done_cycs[1] - done_cycs[0] : -1); end
    tests++; if (chars.size() != 50) begin fails++; $display("FAIL b2b_pulses got %0d want 50", chars.size()); end
    tests++; if (chars.size() < 28 || chars[25] !== 8'h52) begin fails++; $display("FAIL b2b_second_R got %h want 52", chars[25]); end
    tests++; if (chars.size() < 28 || chars[27] !== 8'h33) begin fails++; $display("FAIL b2b_second_ones got %h want 33", chars[27]); end
    tests++; if (chars.size() < 12 || chars[11] !== 8'h41) begin fails++; $display("FAIL b2b_last_nibble got %h want 41", chars[11]); end
    repeat (5) @(posedge clk);
    #2;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_stops got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_line_abcd();
    test_max_values();
    test_ignore_start();
    test_reset_mid_line();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
